// File: rtl/scalar_mult_ctrl_if.sv
// Handshake bundle between the scalar-multiplication sequencer and its
// neighbours: the job intake from the input stage, the command channel to the
// point-arithmetic unit, the result handshake to the output stage, and debug
// status.
//   job_valid/job_m/job_ready : scalar intake (valid/ready)
//   op_valid/op_code/op_ready : command issue (valid/ready)
//   op_done                   : single-cycle completion pulse from the unit
//   res_valid/res_ready       : final-result handshake
//   busy/bit_idx              : controller status for debug
// master = the controller, slave = the surrounding datapath/stages.
interface scalar_mult_ctrl_if #(
  parameter int SCALAR_W = 255,
  parameter int IDX_W    = 8
);
  logic                job_valid;
  logic [SCALAR_W-1:0] job_m;
  logic                job_ready;
  logic                op_valid;
  logic [1:0]          op_code;
  logic                op_ready;
  logic                op_done;
  logic                res_valid;
  logic                res_ready;
  logic                busy;
  logic [IDX_W-1:0]    bit_idx;

  modport master (
    input  job_valid, job_m, op_ready, op_done, res_ready,
    output job_ready, op_valid, op_code, res_valid, busy, bit_idx
  );

  modport slave (
    output job_valid, job_m, op_ready, op_done, res_ready,
    input  job_ready, op_valid, op_code, res_valid, busy, bit_idx
  );
endinterface

// File: rtl/scalar_mult_ctrl.sv
// Sequencer for the point-arithmetic unit: MSB-first double-and-add over a
// SCALAR_W-bit scalar M. Leading zeros are skipped one bit per cycle, the first
// set bit issues LOAD, each lower bit issues DOUBLE and (if set) ADD. M=0
// issues a single CLEAR. Every command waits for its op_done pulse before the
// next one is decided, so only one command is ever outstanding.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset; abandons any job in flight
//   bus     : scalar_mult_ctrl_if.master (job, command, result, debug)
// All outputs decode from registered state only.
module scalar_mult_ctrl #(
  parameter int SCALAR_W = 255,
  parameter int IDX_W    = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  scalar_mult_ctrl_if.master     bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_DOUBLE = 2'b01,
    OP_ADD    = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(SCALAR_W - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e              state, state_next;
  logic [SCALAR_W-1:0] m_r, m_next;
  logic [IDX_W-1:0]    idx_r, idx_next;
  op_e                 op_r, op_next;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      // NOTE: the scalar register is a plain flop bank, not a memory, so it is
      // cleared with the rest of the state; nothing leaks from an abandoned job.
      m_r   <= '0;
      idx_r <= IDX_ZERO;
      op_r  <= OP_LOAD;
    end else begin
      state <= state_next;
      m_r   <= m_next;
      idx_r <= idx_next;
      op_r  <= op_next;
    end
  end

  // Next-state logic
  // NOTE: every target gets a hold-value default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_next = state;
    m_next     = m_r;
    idx_next   = idx_r;
    op_next    = op_r;
    case (state)
      S_IDLE: begin
        // job_ready is high exactly in IDLE, so job_valid alone fires here.
        if (bus.job_valid) begin
          m_next     = bus.job_m;
          idx_next   = IDX_TOP;
          state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (m_r[idx_r]) begin
          op_next    = OP_LOAD;
          state_next = S_ISSUE;
        end else if (idx_r == IDX_ZERO) begin
          op_next    = OP_CLEAR;
          state_next = S_ISSUE;
        end else begin
          idx_next = idx_r - IDX_ONE;
        end
      end
      S_ISSUE: begin
        if (bus.op_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.op_done) begin
          case (op_r)
            OP_CLEAR: state_next = S_DONE;
            OP_DOUBLE: begin
              // A doubled accumulator still owes an ADD for a set bit at the
              // same index before moving down.
              if (m_r[idx_r]) begin
                op_next    = OP_ADD;
                state_next = S_ISSUE;
              end else if (idx_r == IDX_ZERO) begin
                state_next = S_DONE;
              end else begin
                idx_next   = idx_r - IDX_ONE;
                op_next    = OP_DOUBLE;
                state_next = S_ISSUE;
              end
            end
            default: begin  // LOAD or ADD: this bit is fully processed
              if (idx_r == IDX_ZERO) begin
                state_next = S_DONE;
              end else begin
                idx_next   = idx_r - IDX_ONE;
                op_next    = OP_DOUBLE;
                state_next = S_ISSUE;
              end
            end
          endcase
        end
      end
      S_DONE: begin
        if (bus.res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    bus.job_ready = (state == S_IDLE);
    bus.op_valid  = (state == S_ISSUE);
    bus.op_code   = op_r;
    bus.res_valid = (state == S_DONE);
    bus.busy      = (state != S_IDLE);
    bus.bit_idx   = idx_r;
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Self-checking bench for scalar_mult_ctrl. The bench plays the input stage,
// the point-arithmetic unit and the output stage; the expected command stream
// comes from a double-and-add model written directly over the scalar's bits.
module tb_scalar_mult_ctrl;
  localparam int SW = 255;
  localparam int IW = 8;

  localparam logic [1:0] C_LOAD   = 2'b00;
  localparam logic [1:0] C_DOUBLE = 2'b01;
  localparam logic [1:0] C_ADD    = 2'b10;
  localparam logic [1:0] C_CLEAR  = 2'b11;

  logic i_clk = 1'b0;
  logic i_rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [1:0] exp_q[$];
  int   exp_scan;

  scalar_mult_ctrl_if #(.SCALAR_W(SW), .IDX_W(IW)) bus ();

  scalar_mult_ctrl #(.SCALAR_W(SW), .IDX_W(IW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: skip leading zeros, LOAD at the top set bit, then for each
  // lower bit DOUBLE and ADD when that bit is set. Zero scalar -> one CLEAR.
  function automatic void model(input logic [SW-1:0] m);
    int k;
    k = 0;
    exp_q.delete();
    for (int i = SW - 1; i >= 0; i--) begin
      if (m[i]) begin
        k = i;
        break;
      end
    end
    exp_scan = SW - k;
    if (m == '0) begin
      exp_q.push_back(C_CLEAR);
    end else begin
      exp_q.push_back(C_LOAD);
      for (int i = k - 1; i >= 0; i--) begin
        exp_q.push_back(C_DOUBLE);
        if (m[i]) exp_q.push_back(C_ADD);
      end
    end
  endfunction

  function automatic logic [SW-1:0] rand_m();
    logic [255:0] t;
    for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom;
    return t[SW-1:0];
  endfunction

  // Fire a job for m, answer every command, then consume the result.
  // bp    : hold op_ready low for 5 cycles on the first ADD
  // noise : spurious op_done in ISSUE / at fire, job_valid pulses while busy
  task automatic run_job(input logic [SW-1:0] m, input bit bp, input bit noise, input string tag);
    logic [1:0] got_q[$];
    logic [1:0] code;
    int cyc;
    int bad_drop;
    int bad_hold;
    int mism;
    bit bp_done;

    model(m);
    cyc = 0;
    while (!bus.job_ready && cyc < 10) begin tick(); cyc++; end
    check({tag, "_job_ready_idle"}, 32'(bus.job_ready), 32'd1);

    bus.job_valid = 1'b1;
    bus.job_m     = m;
    tick();
    bus.job_valid = 1'b0;
    bus.job_m     = ~m;
    check({tag, "_busy_after_fire"}, 32'(bus.busy), 32'd1);
    check({tag, "_job_ready_busy"}, 32'(bus.job_ready), 32'd0);

    cyc = 0;
    while (!bus.op_valid && cyc < SW + 10) begin
      if (noise) bus.job_valid = cyc[0];
      tick();
      cyc++;
    end
    bus.job_valid = 1'b0;
    check({tag, "_scan_cycles"}, 32'(cyc), 32'(exp_scan));

    bad_drop = 0;
    bad_hold = 0;
    bp_done  = 1'b0;
    cyc      = 0;
    while (!bus.res_valid && cyc < 20000) begin
      if (bus.op_valid) begin
        code = bus.op_code;
        if (noise) begin
          // op_done while the command is still waiting for acceptance
          bus.op_done = 1'b1;
          tick();
          bus.op_done = 1'b0;
          cyc++;
          if (!bus.op_valid || bus.op_code !== code) bad_hold++;
        end
        if (bp && !bp_done && code == C_ADD) begin
          bp_done = 1'b1;
          for (int i = 0; i < 5; i++) begin
            tick();
            cyc++;
            if (!bus.op_valid || bus.op_code !== code) bad_hold++;
          end
        end
        got_q.push_back(code);
        bus.op_ready = 1'b1;
        if (noise) bus.op_done = 1'b1;  // lands on the fire edge
        tick();
        bus.op_ready = 1'b0;
        bus.op_done  = 1'b0;
        if (bus.op_valid) bad_drop++;
        if (noise) begin
          bus.job_valid = 1'b1;
          bus.job_m     = rand_m();
        end
        tick();
        tick();
        bus.job_valid = 1'b0;
        bus.op_done   = 1'b1;
        tick();
        bus.op_done = 1'b0;
        cyc += 4;
      end else begin
        tick();
        cyc++;
      end
    end

    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_cmd_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({tag, "_cmd_seq_mismatches"}, 32'(mism), 32'd0);
    check({tag, "_valid_drop_after_fire"}, 32'(bad_drop), 32'd0);
    check({tag, "_cmd_held_until_fire"}, 32'(bad_hold), 32'd0);
    if (bp) check({tag, "_bp_applied"}, 32'(bp_done), 32'd1);
    check({tag, "_final_bit_idx"}, 32'(bus.bit_idx), 32'd0);
    check({tag, "_job_ready_in_done"}, 32'(bus.job_ready), 32'd0);

    tick();
    tick();
    check({tag, "_res_valid_held"}, 32'(bus.res_valid), 32'd1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, "_res_valid_cleared"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_job_ready_after_res"}, 32'(bus.job_ready), 32'd1);
    check({tag, "_busy_after_res"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [SW-1:0] m;

    i_rst_n       = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_m     = '0;
    bus.op_ready  = 1'b0;
    bus.op_done   = 1'b0;
    bus.res_ready = 1'b0;
    #1;
    check("rst_op_valid", 32'(bus.op_valid), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_bit_idx", 32'(bus.bit_idx), 32'd0);
    check("rst_job_ready", 32'(bus.job_ready), 32'd1);
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();

    run_job(SW'(5), 1'b0, 1'b0, "m5");
    run_job(SW'(1), 1'b0, 1'b0, "m1");
    run_job(SW'(0), 1'b0, 1'b0, "m0");
    run_job({SW{1'b1}}, 1'b0, 1'b0, "ones");
    run_job(SW'(32'h0000_b2d5), 1'b1, 1'b0, "bp");

    m = rand_m();
    run_job(m, 1'b0, 1'b0, "clean_rand");
    run_job(m, 1'b1, 1'b1, "noisy_rand");
    run_job(rand_m() >> $urandom_range(200, 0), 1'b0, 1'b0, "rand_short");

    // Asynchronous reset while a command is outstanding.
    bus.job_valid = 1'b1;
    bus.job_m     = {1'b1, SW'(0)} >> 1;  // bit SW-1 set: one scan cycle
    tick();
    bus.job_valid = 1'b0;
    cyc = 0;
    while (!bus.op_valid && cyc < SW + 10) begin tick(); cyc++; end
    check("rst_mid_issue_reached", 32'(bus.op_valid), 32'd1);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    check("rst_mid_in_wait_busy", 32'(bus.busy), 32'd1);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_op_valid", 32'(bus.op_valid), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_mid_bit_idx", 32'(bus.bit_idx), 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    run_job(SW'(3), 1'b0, 1'b0, "after_rst_m3");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
